// File: rtl/qqspi_arbiter.sv
// -----------------------------------------------------------------------------
// qqspi_arbiter
//
// Purpose:
//   Round-robin arbiter between two bus masters that share one qqspi quad-SPI
//   controller. Master 0 is the CPU and master 1 is a secondary master such as
//   a DMA engine. The winning request is registered, presented to the
//   controller until it answers, and the answer is returned to the owner. The
//   answer is registered read data plus a one-cycle ready pulse.
//
// Optional feature (macro QQSPI_ARB_LOCK_EN):
//   Master 0 may keep ownership across consecutive transactions through
//   m0_lock. This keeps read-modify-write sequences atomic. Without the macro,
//   m0_lock is ignored and arbitration is pure round-robin.
//
// Handshake:
//   A master raises mX_valid with stable request fields and holds them until
//   it sees mX_ready high for one cycle. Toward the controller, s_valid stays
//   high with frozen s_* fields until s_ready is seen. s_ready is ignored
//   whenever no request is outstanding.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mX_valid/addr/wdata/
//   mX_wstrb/psram           master X request (wstrb == 0 means read)
//   m0_lock                  master 0 ownership lock (macro builds only)
//   mX_rdata, mX_ready       registered read data, one-cycle completion pulse
//   s_valid/addr/wdata/
//   s_wstrb/psram            registered request toward qqspi
//   s_rdata, s_ready         controller read data and completion pulse
//   grant                    current or last owner (debug)
// -----------------------------------------------------------------------------
module qqspi_arbiter #(
    parameter int ADDR_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_valid,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wstrb,
    input  logic                  m0_psram,
    input  logic                  m0_lock,
    output logic [31:0]           m0_rdata,
    output logic                  m0_ready,
    input  logic                  m1_valid,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    input  logic                  m1_psram,
    output logic [31:0]           m1_rdata,
    output logic                  m1_ready,
    output logic                  s_valid,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_wstrb,
    output logic                  s_psram,
    input  logic [31:0]           s_rdata,
    input  logic                  s_ready,
    output logic                  grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                state_q;
    logic                  s_valid_q;
    logic [ADDR_WIDTH-1:0] s_addr_q;
    logic [31:0]           s_wdata_q;
    logic [3:0]            s_wstrb_q;
    logic                  s_psram_q;
    logic [31:0]           m0_rdata_q;
    logic [31:0]           m1_rdata_q;
    logic                  m0_ready_q;
    logic                  m1_ready_q;
    logic                  grant_q;
    logic                  last_grant_q;

`ifdef QQSPI_ARB_LOCK_EN
    logic                  lock_held_q;
`else
    logic                  unused_lock;
    assign unused_lock = m0_lock;
`endif

    // Arbitration decision, used only in IDLE.
    logic req0_d;
    logic req1_d;
    logic win_valid_d;
    logic win_m1_d;

    always_comb begin
        req0_d = m0_valid;
        req1_d = m1_valid;
`ifdef QQSPI_ARB_LOCK_EN
        // While master 0 holds the lock, master 1 is invisible to arbitration.
        if (lock_held_q) begin
            req1_d = 1'b0;
        end
`endif
        win_valid_d = req0_d | req1_d;
        // Master 1 wins when it is alone, or when both request and master 0
        // was the previous owner.
        win_m1_d    = req1_d & (~req0_d | ~last_grant_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            s_valid_q    <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_wstrb_q    <= '0;
            s_psram_q    <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
`ifdef QQSPI_ARB_LOCK_EN
            lock_held_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef QQSPI_ARB_LOCK_EN
                    // Master 0 walked away from a held lock without a final
                    // unlocked transaction.
                    if (lock_held_q && !m0_valid && !m0_lock) begin
                        lock_held_q <= 1'b0;
                    end
`endif
                    if (win_valid_d) begin
                        s_addr_q     <= win_m1_d ? m1_addr  : m0_addr;
                        s_wdata_q    <= win_m1_d ? m1_wdata : m0_wdata;
                        s_wstrb_q    <= win_m1_d ? m1_wstrb : m0_wstrb;
                        s_psram_q    <= win_m1_d ? m1_psram : m0_psram;
                        grant_q      <= win_m1_d;
                        last_grant_q <= win_m1_d;
                        s_valid_q    <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The request fields stay frozen until the controller
                    // answers. Writes also latch s_rdata, which is harmless.
                    if (s_ready) begin
                        if (grant_q) begin
                            m1_rdata_q <= s_rdata;
                            m1_ready_q <= 1'b1;
                        end else begin
                            m0_rdata_q <= s_rdata;
                            m0_ready_q <= 1'b1;
                        end
`ifdef QQSPI_ARB_LOCK_EN
                        if (!grant_q) begin
                            lock_held_q <= m0_lock;
                        end
`endif
                        s_valid_q <= 1'b0;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    // Inputs are not sampled here, so a master that still
                    // holds valid for the completed transaction is not
                    // granted again.
                    m0_ready_q <= 1'b0;
                    m1_ready_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_valid  = s_valid_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;
    assign s_psram  = s_psram_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_qqspi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qqspi_arbiter
//
// Directed-plus-random bench for qqspi_arbiter. A behavioural model holds each
// master's pending request, the previous owner and read-data history. It
// predicts the winner of each arbitration and every value the arbiter must
// present. The bench also plays the qqspi controller, answering after a
// chosen latency.
// -----------------------------------------------------------------------------
module tb_qqspi_arbiter;

    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_valid, m1_valid;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_wstrb, m1_wstrb;
    logic          m0_psram, m1_psram;
    logic          m0_lock;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          m0_ready, m1_ready;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic          s_psram;
    logic [31:0]   s_rdata;
    logic          s_ready;
    logic          grant;

    always #5 clk = ~clk;

    qqspi_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_psram (m0_psram),
        .m0_lock  (m0_lock),
        .m0_rdata (m0_rdata),
        .m0_ready (m0_ready),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_psram (m1_psram),
        .m1_rdata (m1_rdata),
        .m1_ready (m1_ready),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_psram  (s_psram),
        .s_rdata  (s_rdata),
        .s_ready  (s_ready),
        .grant    (grant)
    );

    // ---------------- reference model state ----------------
    int            vectors     = 0;
    int            miscompares = 0;
    logic          r_valid [2];
    logic [AW-1:0] r_addr  [2];
    logic [31:0]   r_wdata [2];
    logic [3:0]    r_wstrb [2];
    logic          r_psram [2];
    logic          r_lock;
    logic [31:0]   mdl_rdata [2];
    int            mdl_last;
    logic          mdl_lock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        m0_valid = r_valid[0]; m0_addr = r_addr[0]; m0_wdata = r_wdata[0];
        m0_wstrb = r_wstrb[0]; m0_psram = r_psram[0]; m0_lock = r_lock;
        m1_valid = r_valid[1]; m1_addr = r_addr[1]; m1_wdata = r_wdata[1];
        m1_wstrb = r_wstrb[1]; m1_psram = r_psram[1];
    endtask

    task automatic new_req(input int m, input bit wr);
        r_valid[m] = 1'b1;
        r_addr[m]  = AW'($urandom);
        r_wdata[m] = $urandom;
        r_wstrb[m] = wr ? 4'($urandom_range(1, 15)) : 4'h0;
        r_psram[m] = 1'($urandom_range(0, 1));
    endtask

    task automatic model_reset();
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        mdl_last     = 1;
        mdl_lock     = 1'b0;
    endtask

    // Winner by the arbitration rules: a lone requester wins, contention goes
    // to the master that did not win last time, a held lock hides master 1.
    function automatic int predict();
        if (mdl_lock) return r_valid[0] ? 0 : -1;
        if (r_valid[0] && r_valid[1]) return (mdl_last == 0) ? 1 : 0;
        if (r_valid[0]) return 0;
        if (r_valid[1]) return 1;
        return -1;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_valid"}, 32'(s_valid), 32'd0);
        chk({tag, "_s_addr"},  32'(s_addr),  32'd0);
        chk({tag, "_s_wdata"}, s_wdata,      32'd0);
        chk({tag, "_s_wstrb"}, 32'(s_wstrb), 32'd0);
        chk({tag, "_s_psram"}, 32'(s_psram), 32'd0);
        chk({tag, "_m0_rdata"}, m0_rdata,    32'd0);
        chk({tag, "_m1_rdata"}, m1_rdata,    32'd0);
        chk({tag, "_m0_ready"}, 32'(m0_ready), 32'd0);
        chk({tag, "_m1_ready"}, 32'(m1_ready), 32'd0);
        chk({tag, "_grant"},    32'(grant),    32'd0);
    endtask

    // One whole transaction, starting with the arbiter in IDLE and the
    // requests already driven. lat is the controller latency in cycles (>= 1).
    // keep: the owner issues a fresh request right after its ready pulse.
    task automatic serve(input int lat, input logic [31:0] d, input bit keep);
        int            exp_o;
        int            w;
        logic [AW-1:0] c_addr;
        logic [31:0]   c_wdata;
        logic [3:0]    c_wstrb;
        logic          c_psram;
        exp_o = predict();
        if (exp_o < 0) begin
            chk("serve_no_requester", 32'd0, 32'd1);
            return;
        end
        c_addr  = r_addr[exp_o];
        c_wdata = r_wdata[exp_o];
        c_wstrb = r_wstrb[exp_o];
        c_psram = r_psram[exp_o];
        mdl_last = exp_o;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!s_valid && w < 20);
        chk("issue_latency", 32'(w), 32'd1);
        chk("grant", 32'(grant), 32'(exp_o));
        chk("s_addr", 32'(s_addr), 32'(c_addr));
        chk("s_wdata", s_wdata, c_wdata);
        chk("s_wstrb", 32'(s_wstrb), 32'(c_wstrb));
        chk("s_psram", 32'(s_psram), 32'(c_psram));
        for (int k = 1; k < lat; k++) begin
            // Owner request lines wiggle; the captured request must not.
            if (exp_o == 0) begin
                m0_addr = AW'($urandom); m0_wdata = $urandom; m0_wstrb = 4'($urandom);
                m0_psram = ~c_psram;
            end else begin
                m1_addr = AW'($urandom); m1_wdata = $urandom; m1_wstrb = 4'($urandom);
                m1_psram = ~c_psram;
            end
            @(negedge clk);
            chk("issue_s_valid", 32'(s_valid), 32'd1);
            chk("issue_s_addr", 32'(s_addr), 32'(c_addr));
            chk("issue_s_wdata", s_wdata, c_wdata);
            chk("issue_s_wstrb", 32'(s_wstrb), 32'(c_wstrb));
            chk("issue_s_psram", 32'(s_psram), 32'(c_psram));
            chk("issue_ready", 32'({m1_ready, m0_ready}), 32'd0);
        end
        apply();
        s_ready = 1'b1;
        s_rdata = d;
        @(negedge clk);
        s_ready = 1'b0;
        s_rdata = $urandom;
        mdl_rdata[exp_o] = d;
        if (exp_o == 0) mdl_lock = r_lock;
`ifndef QQSPI_ARB_LOCK_EN
        mdl_lock = 1'b0;
`endif
        chk("resp_m0_ready", 32'(m0_ready), 32'(exp_o == 0));
        chk("resp_m1_ready", 32'(m1_ready), 32'(exp_o == 1));
        chk("resp_m0_rdata", m0_rdata, mdl_rdata[0]);
        chk("resp_m1_rdata", m1_rdata, mdl_rdata[1]);
        chk("resp_s_valid", 32'(s_valid), 32'd0);
        if (keep) new_req(exp_o, 1'($urandom_range(0, 1)));
        else r_valid[exp_o] = 1'b0;
        apply();
        @(negedge clk);
        chk("idle_ready", 32'({m1_ready, m0_ready}), 32'd0);
        chk("idle_s_valid", 32'(s_valid), 32'd0);
    endtask

    initial begin
        // ---- reset ----
        rst = 1'b1;
        s_ready = 1'b0;
        s_rdata = '0;
        for (int m = 0; m < 2; m++) begin
            r_valid[m] = 1'b0; r_addr[m] = '0; r_wdata[m] = '0;
            r_wstrb[m] = '0;   r_psram[m] = 1'b0;
        end
        r_lock = 1'b0;
        apply();
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_request", 32'(s_valid), 32'd0);

        // ---- single read from master 0 ----
        r_valid[0] = 1'b1; r_addr[0] = 23'h000100; r_wdata[0] = $urandom;
        r_wstrb[0] = 4'h0; r_psram[0] = 1'b0;
        apply();
        serve(8, 32'hDEADBEEF, 1'b0);

        // ---- write from master 1 ----
        r_valid[1] = 1'b1; r_addr[1] = AW'($urandom); r_wdata[1] = 32'h12345678;
        r_wstrb[1] = 4'b0011; r_psram[1] = 1'b1;
        apply();
        serve(3, $urandom, 1'b0);

        // ---- contention: both rise together ----
        new_req(0, 1'b0);
        new_req(1, 1'b1);
        apply();
        serve(2, $urandom, 1'b0);
        serve(1, $urandom, 1'b0);

        // ---- fairness: both keep requesting ----
        new_req(0, 1'b0);
        new_req(1, 1'b0);
        apply();
        for (int i = 0; i < 6; i++) serve($urandom_range(1, 4), $urandom, 1'b1);
        serve(1, $urandom, 1'b0);
        serve(1, $urandom, 1'b0);

        // ---- randomized request patterns ----
        for (int i = 0; i < 20; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            if (pat[0]) new_req(0, 1'($urandom_range(0, 1)));
            if (pat[1]) new_req(1, 1'($urandom_range(0, 1)));
            apply();
            for (int j = 0; j < 2 && (r_valid[0] || r_valid[1]); j++)
                serve($urandom_range(1, 6), $urandom, 1'b0);
        end

        // ---- master-0 lock ----
        new_req(0, 1'b0);
        new_req(1, 1'b0);
        r_lock = 1'b1;
        apply();
`ifdef QQSPI_ARB_LOCK_EN
        for (int i = 0; i < 3; i++) serve($urandom_range(1, 3), $urandom, 1'b1);
        r_lock = 1'b0;
        apply();
        serve(2, $urandom, 1'b0);
        serve(2, $urandom, 1'b0);
`else
        serve(2, $urandom, 1'b0);
        serve(2, $urandom, 1'b0);
`endif
        r_lock = 1'b0;
        apply();

        // ---- reset during ISSUE ----
        new_req(0, 1'b0);
        apply();
        serve(1, $urandom, 1'b0);
        new_req(1, 1'b1);
        apply();
        begin
            int w;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!s_valid && w < 20);
            chk("rst_pre_grant", 32'(grant), 32'd1);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("mid_reset");
        model_reset();
        @(negedge clk);
        chk_reset_outputs("held_reset");
        rst = 1'b0;
        new_req(0, 1'b0);
        new_req(1, 1'b0);
        apply();
        serve(3, $urandom, 1'b0);
        serve(1, $urandom, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qqspi_arbiter.md
# qqspi_arbiter

Two-master round-robin arbiter sharing the single `qqspi` quad-SPI controller (SPI NOR flash + PSRAM) between the CPU (master 0) and a secondary bus master such as a DMA or framebuffer fetcher (master 1). It captures the winning request into registers, presents it to the controller and holds it there until the controller responds. It then returns registered read data and a one-cycle ready pulse to the owning master. Optionally, master 0 can lock the controller across consecutive transactions so that atomic read-modify-write sequences are not interleaved.

## Interface
- `ADDR_WIDTH`, default 23: word-address width forwarded to the controller.
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `m0_valid`, `m1_valid`  input  1  request; held until the matching `mX_ready` is seen.
- `m0_addr`, `m1_addr`  input  ADDR_WIDTH  word address.
- `m0_wdata`, `m1_wdata`  input  32  write data.
- `m0_wstrb`, `m1_wstrb`  input  4  byte strobes; 0 means read.
- `m0_psram`, `m1_psram`  input  1  1 selects PSRAM, 0 selects flash.
- `m0_lock`  input  1  hold grant after this transaction (effective only with the macro).
- `m0_rdata`, `m1_rdata`  output  32  registered read data.
- `m0_ready`, `m1_ready`  output  1  one-cycle completion pulse.
- `s_valid`  output  1  request to `qqspi`.
- `s_addr`  output  ADDR_WIDTH  registered address.
- `s_wdata`  output  32  registered write data.
- `s_wstrb`  output  4  registered byte strobes.
- `s_psram`  output  1  registered PSRAM/flash select.
- `s_rdata`  input  32  controller read data.
- `s_ready`  input  1  controller completion pulse.
- `grant`  output  1  current or last owner (0 = master 0, 1 = master 1); debug use.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE:**
  - No request: stay in IDLE.
  - Exactly one `mX_valid` high: grant that master.
  - Both high: grant the master not equal to `last_grant`.
  - On grant: capture the master's addr/wdata/wstrb/psram into the `s_*` registers, set `grant` and `last_grant`, go to ISSUE.
- **ISSUE:**
  - `s_valid` = 1.
  - The `s_*` registers are frozen; changes on master inputs are ignored.
  - On `s_ready`: latch `s_rdata` into the owner's `mX_rdata`, go to RESP.
- **RESP:**
  - Owner's `mX_ready` = 1 for exactly this cycle; `s_valid` = 0.
  - Next state is IDLE.
  - Master inputs are not sampled in RESP. This prevents a master that is still holding `valid` for the same transaction from being re-granted.
- `mX_rdata` of the non-owner holds its previous value.
- Writes also latch `s_rdata`; the content is don't-care, but the ready pulse is mandatory.
- `last_grant` resets to 1, so master 0 wins the first contention.
- Address width is forwarded unchanged; no address decode happens here. The requester sets `mX_psram`.

## Timing
- Reset values:
  - `s_valid`, `m0_ready`, `m1_ready`: 0.
  - `s_addr`, `s_wdata`, `s_wstrb`, `s_psram`, `m0_rdata`, `m1_rdata`: 0.
  - `grant`: 0; `last_grant`: 1; FSM: IDLE.
- Reset asserted mid-transaction: all outputs go to reset values immediately; the captured request is discarded. `qqspi` shares the same reset.
- Request sampled in IDLE at edge N: `s_valid` is high from cycle N+1.
- `s_ready` at edge M: `mX_ready` is high in cycle M+1; FSM is back in IDLE at M+2.
- Added latency: 2 cycles of overhead per transaction, plus the controller latency.
- Back-to-back from the same master: minimum 3 cycles between two `s_valid` rising edges when `qqspi` responds in 1 cycle.
- `s_valid` never deasserts before `s_ready`.
- `s_ready` is ignored outside ISSUE.

## Configuration
- `QQSPI_ARB_LOCK_EN` defined:
  - If `m0_lock`=1 when a master-0 transaction reaches RESP, `lock_held` is set.
  - While `lock_held` is set, IDLE considers only `m0_valid`; master 1 waits indefinitely.
  - `lock_held` clears on a master-0 completion with `m0_lock`=0, or in IDLE when `m0_valid`=0 and `m0_lock`=0.
  - `lock_held` resets to 0.
- `QQSPI_ARB_LOCK_EN` undefined: `m0_lock` is ignored and no `lock_held` register exists; pure round-robin.

## Test plan
- **Single read:** `m0_valid`=1, `m0_addr`=0x000100, `m0_wstrb`=0, `m0_psram`=0; model returns `s_ready` with `s_rdata`=0xDEADBEEF after 8 cycles → `s_addr`=0x000100 and `s_psram`=0 while ISSUE; `m0_ready` pulses once with `m0_rdata`=0xDEADBEEF; `m1_ready` stays 0.
- **Contention after reset:** `m0_valid` and `m1_valid` both rise in the same cycle → master 0 served first, then master 1 (`grant` 0 then 1); exactly one ready pulse each.
- **Fairness:** both masters request continuously for 6 transactions → grants alternate 0,1,0,1,0,1; no master gets two consecutive grants.
- **Write:** `m1_wstrb`=4'b0011, `m1_wdata`=0x12345678, `m1_psram`=1 → `s_wstrb`, `s_wdata` and `s_psram`=1 are stable for the whole of ISSUE; `m1_ready` pulses exactly 1 cycle after `s_ready`.
- **Reset mid-operation:** `rst` asserted 3 cycles into ISSUE → `s_valid`=0 asynchronously; no ready pulses; after release, the next contention grants master 0.
- **Lock (`QQSPI_ARB_LOCK_EN` only):** with `m0_lock`=1 for 3 master-0 transactions while `m1_valid`=1 → master 1 is not granted until the first master-0 completion with `m0_lock`=0; it is granted in the following IDLE.
